// File: rtl/eth_miim_frame.sv
// Clause-22 MII management frame engine: serialises one MDIO frame per command,
// paced by the MDC generator's sample (MdcEn) and drive (MdcEn_n) strobes.
module eth_miim_frame (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MdcEn,
    input  logic        MdcEn_n,
    input  logic        NoPre,
    input  logic [4:0]  Fiad,
    input  logic [4:0]  Rgad,
    input  logic [15:0] CtrlData,
    input  logic        WCtrlData,
    input  logic        RStat,
    input  logic        Mdi,
    output logic        Mdo,
    output logic        MdoEn,
    output logic        Busy,
    output logic [15:0] Prsd,
    output logic        RStatDone,
    output logic        WCtrlDataDone
);

    typedef enum logic [1:0] {StIdle, StArmed, StShift} state_e;

    state_e      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        mdo_q, mdo_d, mdo_en_q, mdo_en_d, busy_q, busy_d;
    logic        rstat_done_q, rstat_done_d, wctrl_done_q, wctrl_done_d;
    logic [15:0] prsd_q, prsd_d, rx_q, rx_d, wdata_q, wdata_d;
    logic [4:0]  fiad_q, fiad_d, rgad_q, rgad_d;
    logic        nopre_q, nopre_d, rd_q, rd_d;
    logic [63:0] frame;
    logic [5:0]  start_cnt, next_cnt;

    // Bit n of the frame sits at frame[63-n]; released read bits are zero.
    assign frame     = {32'hFFFF_FFFF, 2'b01, rd_q ? 2'b10 : 2'b01, fiad_q, rgad_q,
                        rd_q ? 2'b00 : 2'b10, rd_q ? 16'h0000 : wdata_q};
    assign start_cnt = nopre_q ? 6'd32 : 6'd0;
    assign next_cnt  = bit_cnt_q + 6'd1;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        mdo_d        = mdo_q;
        mdo_en_d     = mdo_en_q;
        busy_d       = busy_q;
        prsd_d       = prsd_q;
        rx_d         = rx_q;
        wdata_d      = wdata_q;
        fiad_d       = fiad_q;
        rgad_d       = rgad_q;
        nopre_d      = nopre_q;
        rd_d         = rd_q;
        rstat_done_d = 1'b0;
        wctrl_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The Done cycle still counts as busy for command acceptance.
                if ((WCtrlData || RStat) && !rstat_done_q && !wctrl_done_q) begin
                    fiad_d  = Fiad;
                    rgad_d  = Rgad;
                    wdata_d = CtrlData;
                    nopre_d = NoPre;
                    rd_d    = !WCtrlData;
                    busy_d  = 1'b1;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (MdcEn_n) begin
                    bit_cnt_d = start_cnt;
                    mdo_d     = frame[6'd63 - start_cnt];
                    mdo_en_d  = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (MdcEn_n) begin
                    if (bit_cnt_q != 6'd63) begin
                        bit_cnt_d = next_cnt;
                        mdo_en_d  = !(rd_q && next_cnt >= 6'd46);
                        mdo_d     = mdo_en_d & frame[6'd63 - next_cnt];
                    end else begin
                        state_d  = StIdle;
                        mdo_d    = 1'b0;
                        mdo_en_d = 1'b0;
                        busy_d   = 1'b0;
                        if (rd_q) begin
                            prsd_d       = rx_q;
                            rstat_done_d = 1'b1;
                        end else begin
                            wctrl_done_d = 1'b1;
                        end
                    end
                end else if (MdcEn && rd_q && bit_cnt_q >= 6'd48) begin
                    rx_d = {rx_q[14:0], Mdi};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 6'd0;
            mdo_q        <= 1'b0;
            mdo_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            prsd_q       <= 16'h0000;
            rx_q         <= 16'h0000;
            wdata_q      <= 16'h0000;
            fiad_q       <= 5'd0;
            rgad_q       <= 5'd0;
            nopre_q      <= 1'b0;
            rd_q         <= 1'b0;
            rstat_done_q <= 1'b0;
            wctrl_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            mdo_q        <= mdo_d;
            mdo_en_q     <= mdo_en_d;
            busy_q       <= busy_d;
            prsd_q       <= prsd_d;
            rx_q         <= rx_d;
            wdata_q      <= wdata_d;
            fiad_q       <= fiad_d;
            rgad_q       <= rgad_d;
            nopre_q      <= nopre_d;
            rd_q         <= rd_d;
            rstat_done_q <= rstat_done_d;
            wctrl_done_q <= wctrl_done_d;
        end
    end

    assign Mdo           = mdo_q;
    assign MdoEn         = mdo_en_q;
    assign Busy          = busy_q;
    assign Prsd          = prsd_q;
    assign RStatDone     = rstat_done_q;
    assign WCtrlDataDone = wctrl_done_q;

endmodule

// File: tb/tb_eth_miim_frame.sv
// Scoreboard bench for eth_miim_frame: expected frames are queued at issue and
// checked by a monitor that captures Mdo/MdoEn at every Mdc sample point.
module tb_eth_miim_frame;

    logic        Clk = 1'b0, Reset = 1'b1, NoPre = 1'b0, WCtrlData = 1'b0, RStat = 1'b0;
    logic        Mdi = 1'b0;
    logic [4:0]  Fiad = 5'd0, Rgad = 5'd0;
    logic [15:0] CtrlData = 16'h0000;
    logic        MdcEn, MdcEn_n, Mdo, MdoEn, Busy, RStatDone, WCtrlDataDone;
    logic [15:0] Prsd;

    typedef struct {
        logic [63:0] mdo;
        logic [63:0] en;
        int          bits;
        bit          rd;
        logic [15:0] prsd;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0;
    int          div = 8, mdc_cnt = 0;
    int          done_count = 0, mon_idx = 0;
    bit          collecting = 1'b0;
    logic [15:0] phy_data = 16'h1234;

    eth_miim_frame dut (
        .Clk(Clk), .Reset(Reset), .MdcEn(MdcEn), .MdcEn_n(MdcEn_n), .NoPre(NoPre),
        .Fiad(Fiad), .Rgad(Rgad), .CtrlData(CtrlData), .WCtrlData(WCtrlData),
        .RStat(RStat), .Mdi(Mdi), .Mdo(Mdo), .MdoEn(MdoEn), .Busy(Busy), .Prsd(Prsd),
        .RStatDone(RStatDone), .WCtrlDataDone(WCtrlDataDone)
    );

    always #5 Clk = ~Clk;

    // MDC generator model: sample strobe at phase 0, drive strobe half a period later.
    always @(posedge Clk) mdc_cnt <= (mdc_cnt + 1 >= div) ? 0 : mdc_cnt + 1;
    assign MdcEn   = (mdc_cnt == 0);
    assign MdcEn_n = (mdc_cnt == div / 2);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic expect_frame(input logic [63:0] mdo, input logic [63:0] en, input int bits,
                                input bit rd, input logic [15:0] prsd);
        exp_t e;
        e.mdo  = mdo;
        e.en   = en;
        e.bits = bits;
        e.rd   = rd;
        e.prsd = prsd;
        sb.push_back(e);
    endtask

    task automatic issue(input bit wr, input bit rd, input logic [4:0] fa, input logic [4:0] ra,
                         input logic [15:0] d, input bit np);
        @(negedge Clk);
        Fiad = fa; Rgad = ra; CtrlData = d; NoPre = np; WCtrlData = wr; RStat = rd;
        @(negedge Clk);
        WCtrlData = 1'b0; RStat = 1'b0;
        Fiad = ~fa; Rgad = ~ra; CtrlData = ~d; NoPre = ~np;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (sb.size() == 0 && !Busy) break;
        end
        if (i == 4000) fail_now({name, "_timeout"});
    endtask

    // Monitor: capture one bit per Mdc rising edge, compare the whole frame at Done.
    initial begin
        exp_t        e;
        logic [63:0] got_mdo, got_en, mask;
        int          cnt, start;
        cnt = 0; start = 0; got_mdo = '0; got_en = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                collecting = 1'b0;
                Mdi = 1'b0;
            end else if (RStatDone || WCtrlDataDone) begin
                done_count++;
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    mask = (e.bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
                    chk("bit_count", 64'(cnt), 64'(e.bits));
                    chk("mdo_bits", got_mdo & mask, e.mdo & mask);
                    chk("mdoen_bits", got_en & mask, e.en & mask);
                    chk("done_kind", {RStatDone, WCtrlDataDone}, e.rd ? 2'b10 : 2'b01);
                    chk("prsd", Prsd, e.prsd);
                    chk("busy_at_done", Busy, 1'b0);
                end
                collecting = 1'b0;
            end else begin
                if (!collecting && MdoEn) begin
                    collecting = 1'b1;
                    cnt = 0; got_mdo = '0; got_en = '0;
                    start = (sb.size() > 0 && sb[0].bits == 32) ? 32 : 0;
                end
                if (collecting && MdcEn) begin
                    mon_idx = start + cnt;
                    if (mon_idx <= 63) begin
                        got_mdo[63 - mon_idx] = Mdo;
                        got_en[63 - mon_idx]  = MdoEn;
                    end
                    cnt++;
                    // PHY drives read data so it is stable at this sample edge.
                    Mdi = (mon_idx >= 48 && mon_idx <= 63) ? phy_data[63 - mon_idx] : 1'b0;
                end
            end
        end
    end

    initial begin
        int i;
        repeat (3) @(negedge Clk);
        chk("rst_mdo", Mdo, 1'b0);
        chk("rst_mdoen", MdoEn, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_prsd", Prsd, 16'h0000);
        chk("rst_rstatdone", RStatDone, 1'b0);
        chk("rst_wdone", WCtrlDataDone, 1'b0);
        Reset = 1'b0;

        // Write, full preamble.
        expect_frame(64'hFFFF_FFFF_5092_A5C3, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 16'h0000);
        issue(1'b1, 1'b0, 5'h01, 5'h04, 16'hA5C3, 1'b0);
        @(negedge Clk);
        chk("busy_after_cmd", Busy, 1'b1);
        wait_idle("write1");

        // Read: TA and data released, PHY returns 0x1234.
        expect_frame(64'hFFFF_FFFF_6F88_0000, 64'hFFFF_FFFF_FFFC_0000, 64, 1'b1, 16'h1234);
        issue(1'b0, 1'b1, 5'h1F, 5'h02, 16'h0000, 1'b0);
        wait_idle("read1");

        // No preamble: 32 bits only.
        expect_frame(64'h0000_0000_52C6_FFFF, 64'h0000_0000_FFFF_FFFF, 32, 1'b0, 16'h1234);
        issue(1'b1, 1'b0, 5'h05, 5'h11, 16'hFFFF, 1'b1);
        wait_idle("nopre");

        // Simultaneous write+read, then a read strobe mid-frame: one write only.
        expect_frame(64'hFFFF_FFFF_5556_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 16'h1234);
        issue(1'b1, 1'b1, 5'h0A, 5'h15, 16'h0F0F, 1'b0);
        repeat (200) @(negedge Clk);
        RStat = 1'b1;
        @(negedge Clk);
        RStat = 1'b0;
        wait_idle("collide");
        repeat (300) @(negedge Clk);
        chk("no_extra_frame_busy", Busy, 1'b0);
        chk("frames_so_far", 64'(done_count), 64'd4);

        // Reset in the middle of a read.
        phy_data = 16'hCAFE;
        expect_frame(64'h0, 64'h0, 64, 1'b1, 16'hCAFE);
        issue(1'b0, 1'b1, 5'h03, 5'h03, 16'h0000, 1'b0);
        for (i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (collecting && mon_idx >= 40) break;
        end
        if (i == 4000) fail_now("reach_bit40_timeout");
        #2 Reset = 1'b1;
        #1;
        chk("midrst_mdo", Mdo, 1'b0);
        chk("midrst_mdoen", MdoEn, 1'b0);
        chk("midrst_busy", Busy, 1'b0);
        chk("midrst_prsd", Prsd, 16'h0000);
        sb.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        expect_frame(64'hFFFF_FFFF_5002_8001, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 16'h0000);
        issue(1'b1, 1'b0, 5'h00, 5'h00, 16'h8001, 1'b0);
        wait_idle("post_reset");

        // Fast Mdc; command on the Done cycle is ignored, one Clk later is taken.
        div = 2;
        expect_frame(64'h0000_0000_519E_1357, 64'h0000_0000_FFFF_FFFF, 32, 1'b0, 16'h0000);
        issue(1'b1, 1'b0, 5'h03, 5'h07, 16'h1357, 1'b1);
        for (i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (WCtrlDataDone) break;
        end
        if (i == 4000) fail_now("fast_done_timeout");
        Fiad = 5'h02; Rgad = 5'h02; CtrlData = 16'hDEAD; NoPre = 1'b0; WCtrlData = 1'b1;
        @(negedge Clk);
        expect_frame(64'hFFFF_FFFF_5F06_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 16'h0000);
        Fiad = 5'h1E; Rgad = 5'h01; CtrlData = 16'hBEEF; NoPre = 1'b0;
        @(negedge Clk);
        WCtrlData = 1'b0; CtrlData = 16'h0000;
        wait_idle("back_to_back");
        repeat (20) @(negedge Clk);
        chk("frames_total", 64'(done_count), 64'd7);
        chk("final_busy", Busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_miim_frame.md
Name: eth_miim_frame

Overview:
MII management (MDIO) frame engine, directly downstream of the MDC clock generator. It consumes the generator's MdcEn / MdcEn_n strobes and serialises one IEEE 802.3 clause-22 management frame per command: preamble, ST, OP, PHYAD, REGAD, TA and 16-bit data. Reads capture the PHY response into Prsd. The MDIO pad (Mdo/MdoEn/Mdi) is assembled at the top level.

Parameters:
None. The frame format is fixed to clause 22.

Ports:
Clk  input  1  host clock, same clock that drives the MDC clock generator
Reset  input  1  asynchronous, active-high reset
MdcEn  input  1  one-Clk strobe before Mdc rises; sample point
MdcEn_n  input  1  one-Clk strobe before Mdc falls; drive point
NoPre  input  1  1 = omit the 32-bit preamble
Fiad  input  5  PHY address
Rgad  input  5  register address
CtrlData  input  16  write data
WCtrlData  input  1  write command strobe, one Clk
RStat  input  1  read command strobe, one Clk
Mdi  input  1  MDIO input from the pad
Mdo  output  1  MDIO output data
MdoEn  output  1  MDIO output enable (1 = drive)
Busy  output  1  a frame is pending or in progress
Prsd  output  16  last read data
RStatDone  output  1  one-Clk pulse when Prsd is updated
WCtrlDataDone  output  1  one-Clk pulse at the end of a write frame

Behaviour:
- Reset (asynchronous, takes effect at once, including mid-frame): state=IDLE, Mdo=0, MdoEn=0, Busy=0, Prsd=0, both Done pulses=0, BitCnt=0, RX shift register=0.
- Bit map, BitCnt 0..63:
  - 0-31: preamble, all 1.
  - 32-33: ST = 0,1.
  - 34-35: OP = 0,1 for write; 1,0 for read.
  - 36-40: Fiad, MSB first.
  - 41-45: Rgad, MSB first.
  - 46-47: TA = 1,0 for write; released for read.
  - 48-63: data, MSB first (CtrlData for write; from the PHY for read).
- IDLE:
  - On WCtrlData or RStat: latch Fiad, Rgad, CtrlData, NoPre and op. Busy=1 from the next Clk. Go ARMED.
  - If WCtrlData and RStat arrive in the same cycle, the write wins and the read is dropped.
- ARMED: wait for MdcEn_n. On it: BitCnt = 32 if the latched NoPre is 1, else 0. Mdo = bit(BitCnt). MdoEn=1. Go SHIFT.
- SHIFT, on MdcEn:
  - If op=read and BitCnt is 48..63: RX = {RX[14:0], Mdi}.
  - Mdo and MdoEn do not change.
- SHIFT, on MdcEn_n with BitCnt<63:
  - BitCnt++; Mdo = bit(new BitCnt).
  - MdoEn = 0 for a read when the new BitCnt >= 46; otherwise MdoEn = 1.
  - Mdo = 0 whenever MdoEn = 0.
- SHIFT, on MdcEn_n with BitCnt==63:
  - Go IDLE; Mdo=0, MdoEn=0, Busy=0 on the same edge.
  - Read: Prsd = RX and RStatDone pulses. Write: WCtrlDataDone pulses.
- All outputs are registered. Mdo changes only on the Clk after an MdcEn_n strobe, i.e. with Mdc falling, and is stable at the rising edge.
- Frame length: 64 Mdc periods, or 32 with NoPre. One extra 0..1 Mdc period of ARMED latency follows the command.
- Command strobes while Busy=1, including the Done cycle, are ignored.
- Inputs Fiad/Rgad/CtrlData/NoPre may change after acceptance without effect.
- MdcEn and MdcEn_n are never asserted in the same cycle; the generator guarantees this. If both are seen anyway, MdcEn_n takes priority and no sample is taken.
- A strobe arriving in the same cycle as MdcEn_n while IDLE is latched. The frame starts at the next MdcEn_n, not that one.

Test Plan:
- Write: Fiad=0x01, Rgad=0x04, CtrlData=0xA5C3, NoPre=0, Divider=8 -> Mdo sampled at 64 rising Mdc edges = 32x1, 01, 01, 00001, 00100, 10, 1010010111000011. MdoEn=1 throughout. WCtrlDataDone pulses once. Busy low afterwards.
- Read: PHY model drives 0x1234 MSB first on bits 48..63; Fiad=0x1F, Rgad=0x02 -> OP bits = 10. MdoEn=0 for the last 18 bits. Prsd=0x1234 and RStatDone pulses on the same Clk that Busy falls.
- NoPre=1 write of 0xFFFF -> exactly 32 Mdc periods with MdoEn=1. The first driven bits are 0,1 (ST), with no preamble.
- WCtrlData and RStat together, then RStat pulsed mid-frame -> exactly one write frame. No read occurs; Prsd is unchanged.
- Reset asserted at BitCnt=40 of a read -> MdoEn=0, Mdo=0, Busy=0 immediately, Prsd=0. A new write after reset completes a normal 64-bit frame.
- Divider=2 (MdcEn/MdcEn_n on alternate Clk) with back-to-back commands issued on the Done cycle -> the issued command is ignored. A command issued one Clk later is accepted and its frame is correct.
